alu16_sequencer: RTL and testbench

Multi-cycle controller that executes 16-bit operations on the 8-bit combinational ALU by sequencing byte-wide ALU commands over consecutive clocks. It sits between the core's decode/execute control and the ALU: it accepts a 16-bit request with a start/done handshake, drives the ALU's command and operand inputs each cycle, and captures the ALU's 8-bit result into a 16-bit result register. Carry and borrow between bytes are derived locally, since the ALU has no carry output.

---
 rtl/alu16_pkg.sv | 39 +++
 rtl/alu16_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_alu16_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/alu16_pkg.sv
// Shared types and constants for the 16-bit sequencer and the 8-bit ALU.
//   op_t    : 16-bit operation select seen by the sequencer
//   state_t : sequencer FSM states
//   Alu*    : ALU command encodings driven on alu_cmd
//   Sh*     : shift direction sub-op carried in alu_last5bits[1:0]
package alu16_pkg;

    typedef enum logic [2:0] {
        OpAdd16  = 3'b000,
        OpSub16  = 3'b001,
        OpShl16  = 3'b010,
        OpShr16  = 3'b011,
        OpXor16  = 3'b100,
        OpAnd16  = 3'b101,
        OpPass6  = 3'b110,
        OpPass7  = 3'b111
    } op_t;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLo   = 3'd1,
        StHi   = 3'd2,
        StFix  = 3'd3,
        StDone = 3'd4
    } state_t;

    localparam logic [2:0] AluAdd    = 3'b000;
    localparam logic [2:0] AluShift  = 3'b001;
    localparam logic [2:0] AluExcess = 3'b010;
    localparam logic [2:0] AluXor    = 3'b011;
    localparam logic [2:0] AluAnd    = 3'b100;
    localparam logic [2:0] AluOr     = 3'b101;
    localparam logic [2:0] AluSub    = 3'b110;
    localparam logic [2:0] AluPassA  = 3'b111;

    localparam logic [1:0] ShLsl = 2'b00;
    localparam logic [1:0] ShLsr = 2'b10;

endpackage

// File: rtl/alu16_sequencer.sv
// Runs 16-bit operations on an external 8-bit combinational ALU by issuing one
// byte-wide command per clock (low byte, high byte, optional carry/borrow fix).
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start, op, a, b,    : request handshake and operands (sampled in idle only)
//   shamt
//   busy, done          : status; done pulses one cycle with results valid
//   result, cout, zero16: registered 16-bit result, carry/borrow, zero flag
//   alu_cmd, alu_inA,   : command/operands driven to the ALU
//   alu_inB, alu_imm,
//   alu_last5bits
//   alu_rslt            : 8-bit ALU result
module alu16_sequencer
    import alu16_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [2:0]  shamt,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        cout,
    output logic        zero16,
    output logic [2:0]  alu_cmd,
    output logic [7:0]  alu_inA,
    output logic [7:0]  alu_inB,
    output logic        alu_imm,
    output logic [4:0]  alu_last5bits,
    input  logic [7:0]  alu_rslt
);

    state_t      state_q;
    op_t         op_q;
    logic [15:0] a_q, b_q, result_q;
    logic [2:0]  shamt_q;
    logic        c_q, cout_q, busy_q, done_q;
    logic [2:0]  shr_amt;

    // Low byte of a right shift is the top byte of {a_hi,a_lo} shifted left by 8-k.
    assign shr_amt = 3'(4'd8 - {1'b0, shamt_q});

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= OpAdd16;
            a_q      <= '0;
            b_q      <= '0;
            shamt_q  <= '0;
            c_q      <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q    <= op_t'(op);
                        a_q     <= a;
                        b_q     <= b;
                        shamt_q <= shamt;
                        cout_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StLo;
                    end
                end
                StLo: begin
                    result_q[7:0] <= alu_rslt;
                    // Carry: wrapped sum is smaller than an addend. Borrow: a < b.
                    c_q <= (op_q == OpAdd16) ? (alu_rslt < a_q[7:0]) : (a_q[7:0] < b_q[7:0]);
                    state_q <= StHi;
                end
                StHi: begin
                    result_q[15:8] <= alu_rslt;
                    if (op_q == OpAdd16) cout_q <= (alu_rslt < a_q[15:8]);
                    if (op_q == OpSub16) cout_q <= (a_q[15:8] < b_q[15:8]);
                    if (op_q == OpAdd16 || op_q == OpSub16) begin
                        state_q <= StFix;
                    end else begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StFix: begin
                    result_q[15:8] <= alu_rslt;
                    // Fix-up only carries out when the high byte wraps across it.
                    if (op_q == OpAdd16) cout_q <= cout_q | (c_q & (result_q[15:8] == 8'hFF));
                    else                 cout_q <= cout_q | (c_q & (result_q[15:8] == 8'h00));
                    state_q <= StDone;
                    done_q  <= 1'b1;
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        alu_cmd       = AluPassA;
        alu_inA       = 8'h00;
        alu_inB       = 8'h00;
        alu_last5bits = 5'b0;
        unique case (state_q)
            StLo: begin
                alu_inA = a_q[7:0];
                alu_inB = b_q[7:0];
                case (op_q)
                    OpAdd16: alu_cmd = AluAdd;
                    OpSub16: alu_cmd = AluSub;
                    OpXor16: alu_cmd = AluXor;
                    OpAnd16: alu_cmd = AluAnd;
                    OpShl16: begin
                        alu_cmd       = AluShift;
                        alu_inB       = 8'h00;
                        alu_last5bits = {shamt_q, ShLsl};
                    end
                    OpShr16: begin
                        if (shamt_q != 3'd0) begin
                            alu_cmd       = AluExcess;
                            alu_inB       = a_q[15:8];
                            alu_last5bits = {shr_amt, ShLsl};
                        end else begin
                            alu_cmd = AluPassA;
                            alu_inB = 8'h00;
                        end
                    end
                    default: begin
                        alu_cmd = AluPassA;
                        alu_inB = 8'h00;
                    end
                endcase
            end
            StHi: begin
                alu_inA = a_q[15:8];
                alu_inB = b_q[15:8];
                case (op_q)
                    OpAdd16: alu_cmd = AluAdd;
                    OpSub16: alu_cmd = AluSub;
                    OpXor16: alu_cmd = AluXor;
                    OpAnd16: alu_cmd = AluAnd;
                    OpShl16: begin
                        alu_cmd       = AluExcess;
                        alu_inA       = a_q[7:0];
                        alu_inB       = a_q[15:8];
                        alu_last5bits = {shamt_q, ShLsl};
                    end
                    OpShr16: begin
                        alu_cmd       = AluShift;
                        alu_inB       = 8'h00;
                        alu_last5bits = {shamt_q, ShLsr};
                    end
                    default: begin
                        alu_cmd = AluPassA;
                        alu_inB = 8'h00;
                    end
                endcase
            end
            StFix: begin
                alu_cmd = (op_q == OpSub16) ? AluSub : AluAdd;
                alu_inA = result_q[15:8];
                alu_inB = {7'b0, c_q};
            end
            default: ;
        endcase
    end

    assign alu_imm = 1'b0;
    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign cout    = cout_q;
    assign zero16  = (result_q == 16'h0000);

endmodule

// File: tb/tb_alu16_sequencer.sv
module tb_alu16_sequencer;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  op, shamt;
    logic [15:0] a, b;
    logic        busy, done, cout, zero16, alu_imm;
    logic [15:0] result;
    logic [2:0]  alu_cmd;
    logic [7:0]  alu_inA, alu_inB, alu_rslt;
    logic [4:0]  alu_last5bits;
    logic [15:0] alu_wide;

    int checks = 0;
    int errors = 0;
    int imm_bad = 0;

    always #5 clk = ~clk;

    alu16_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .shamt(shamt),
        .busy(busy), .done(done), .result(result), .cout(cout), .zero16(zero16),
        .alu_cmd(alu_cmd), .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_imm(alu_imm),
        .alu_last5bits(alu_last5bits), .alu_rslt(alu_rslt)
    );

    // Behavioural 8-bit ALU standing in for the datapath ALU.
    always_comb begin
        alu_wide = {alu_inB, alu_inA} << alu_last5bits[4:2];
        case (alu_cmd)
            3'b000:  alu_rslt = alu_inA + alu_inB;
            3'b001:  alu_rslt = (alu_last5bits[1:0] == 2'b10) ? (alu_inA >> alu_last5bits[4:2])
                                                              : (alu_inA << alu_last5bits[4:2]);
            3'b010:  alu_rslt = alu_wide[15:8];
            3'b011:  alu_rslt = alu_inA ^ alu_inB;
            3'b100:  alu_rslt = alu_inA & alu_inB;
            3'b101:  alu_rslt = alu_inA | alu_inB;
            3'b110:  alu_rslt = alu_inA - alu_inB;
            default: alu_rslt = alu_inA;
        endcase
    end

    always @(negedge clk) if (alu_imm !== 1'b0) imm_bad++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one request, scramble inputs after acceptance, wait up to 8 cycles for done.
    task automatic run_op(input logic [2:0] o, input logic [15:0] ia, input logic [15:0] ib,
                          input logic [2:0] sh, output logic [15:0] r, output logic c,
                          output logic z, output int lat);
        int ndone = 0;
        lat = -1; r = 'x; c = 1'bx; z = 1'bx;
        @(negedge clk);
        op = o; a = ia; b = ib; shamt = sh; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); op = 3'($urandom); shamt = 3'($urandom);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc == 1) chk("busy_after_accept", 32'(busy), 32'd1);
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = cyc; r = result; c = cout; z = zero16;
                    chk("busy_in_done", 32'(busy), 32'd1);
                end
            end
        end
        chk("done_pulse_count", 32'(ndone), 32'd1);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a, b;
        logic [2:0]  sh;
        logic [15:0] res;
        logic        cout, zero;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [15:0] r, er;
        logic        c, z, ec;
        int          lat;
        logic [16:0] sum;
        int          ndone;

        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; shamt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_zero16", 32'(zero16), 32'd1);
        chk("rst_alu_cmd", 32'(alu_cmd), 32'd7);
        chk("rst_alu_inA", 32'(alu_inA), 32'd0);
        chk("rst_alu_inB", 32'(alu_inB), 32'd0);
        chk("rst_alu_last5", 32'(alu_last5bits), 32'd0);
        reset = 1'b0;

        vecs.push_back('{3'd0, 16'h12FF, 16'h0001, 3'd0, 16'h1300, 1'b0, 1'b0, 4});
        vecs.push_back('{3'd0, 16'hFFFF, 16'h0001, 3'd0, 16'h0000, 1'b1, 1'b1, 4});
        vecs.push_back('{3'd0, 16'h00FF, 16'h0001, 3'd0, 16'h0100, 1'b0, 1'b0, 4});
        vecs.push_back('{3'd1, 16'h1000, 16'h0001, 3'd0, 16'h0FFF, 1'b0, 1'b0, 4});
        vecs.push_back('{3'd1, 16'h0000, 16'h0001, 3'd0, 16'hFFFF, 1'b1, 1'b0, 4});
        vecs.push_back('{3'd2, 16'h81C3, 16'h0000, 3'd3, 16'h0E18, 1'b0, 1'b0, 3});
        vecs.push_back('{3'd3, 16'h81C3, 16'h0000, 3'd3, 16'h1038, 1'b0, 1'b0, 3});
        vecs.push_back('{3'd3, 16'h81C3, 16'h0000, 3'd0, 16'h81C3, 1'b0, 1'b0, 3});
        vecs.push_back('{3'd4, 16'hA5A5, 16'hFFFF, 3'd0, 16'h5A5A, 1'b0, 1'b0, 3});
        vecs.push_back('{3'd5, 16'hF0F0, 16'h0FF0, 3'd0, 16'h00F0, 1'b0, 1'b0, 3});
        vecs.push_back('{3'd7, 16'h1234, 16'h5678, 3'd5, 16'h1234, 1'b0, 1'b0, 3});
        vecs.push_back('{3'd6, 16'hBEEF, 16'h0001, 3'd0, 16'hBEEF, 1'b0, 1'b0, 3});

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, r, c, z, lat);
            chk($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].res));
            chk($sformatf("vec%0d_cout", i), 32'(c), 32'(vecs[i].cout));
            chk($sformatf("vec%0d_zero16", i), 32'(z), 32'(vecs[i].zero));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Randomised requests against an arithmetic reference.
        for (int n = 0; n < 150; n++) begin
            logic [2:0]  ro, rs;
            logic [15:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = (n % 10 == 0) ? 16'hFFFF : 16'($urandom);
            rb = (n % 7 == 0) ? ra : 16'($urandom);
            rs = 3'($urandom);
            ec = 1'b0;
            case (ro)
                3'd0: begin sum = {1'b0, ra} + {1'b0, rb}; er = sum[15:0]; ec = sum[16]; end
                3'd1: begin er = ra - rb; ec = (ra < rb); end
                3'd2: er = ra << rs;
                3'd3: er = ra >> rs;
                3'd4: er = ra ^ rb;
                3'd5: er = ra & rb;
                default: er = ra;
            endcase
            run_op(ro, ra, rb, rs, r, c, z, lat);
            chk($sformatf("rnd%0d_op%0d_result", n, ro), 32'(r), 32'(er));
            chk($sformatf("rnd%0d_op%0d_cout", n, ro), 32'(c), 32'(ec));
            chk($sformatf("rnd%0d_op%0d_zero16", n, ro), 32'(z), 32'(er == 16'h0));
            chk($sformatf("rnd%0d_op%0d_latency", n, ro), 32'(lat), (ro < 3'd2) ? 32'd4 : 32'd3);
        end

        // start held high: in-flight requests ignore it, then reset lands mid-operation.
        @(negedge clk);
        op = 3'd0; a = 16'h12FF; b = 16'h0001; shamt = 3'd0; start = 1'b1;
        @(posedge clk);
        #1;
        op = 3'd4; a = 16'hFFFF; b = 16'hFFFF;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge clk);
            chk($sformatf("hold_done_c%0d", cyc), 32'(done), 32'd0);
            chk($sformatf("hold_busy_c%0d", cyc), 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk("hold_done_e4", 32'(done), 32'd1);
        chk("hold_result", 32'(result), 32'h1300);
        chk("hold_cout", 32'(cout), 32'd0);
        @(negedge clk);
        chk("hold_gap_busy", 32'(busy), 32'd0);
        chk("hold_gap_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("hold_reaccept_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("hold_hi_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        chk("midrst_zero16", 32'(zero16), 32'd1);
        chk("midrst_alu_cmd", 32'(alu_cmd), 32'd7);
        ndone = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midrst_no_done", 32'(ndone), 32'd0);
        run_op(3'd0, 16'hFFFF, 16'h0001, 3'd0, r, c, z, lat);
        chk("post_rst_result", 32'(r), 32'h0000);
        chk("post_rst_cout", 32'(c), 32'd1);
        chk("post_rst_zero16", 32'(z), 32'd1);
        chk("post_rst_latency", 32'(lat), 32'd4);

        chk("alu_imm_zero", 32'(imm_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
